bus4to1_rr: RTL and testbench

Four-master, one-slave round-robin arbiter for the native valid/ready memory bus (valid, ready, addr, rdata, wdata, wstrb). It shares one slave, typically the unified memory or peripheral bus, between up to four masters such as I-fetch, D-access, DMA and debug. A bus-hang timeout completes a stuck transaction with an error word and captures diagnostic state.

---
 rtl/bus4to1_rr.sv | 221 ++++++++++++++++++++++
 tb/tb_bus4to1_rr.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus4to1_rr.sv
// Four-master round-robin arbiter onto one native valid/ready slave.
// A bus-hang timeout completes a stuck owner with an error word.
module bus4to1_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m2_valid,
  output logic        m2_ready,
  input  logic [31:0] m2_addr,
  output logic [31:0] m2_rdata,
  input  logic [31:0] m2_wdata,
  input  logic [3:0]  m2_wstrb,
  input  logic        m3_valid,
  output logic        m3_ready,
  input  logic [31:0] m3_addr,
  output logic [31:0] m3_rdata,
  input  logic [31:0] m3_wdata,
  input  logic [3:0]  m3_wstrb,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [3:0]  s_wstrb,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        err_flag,
  output logic [1:0]  err_master,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TMO_LAST =
    TMO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_flag_q, err_flag_d;
  logic [1:0]  err_master_q, err_master_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [3:0]  m_valid;
  logic [31:0] m_addr [4];
  logic [31:0] m_wdata [4];
  logic [3:0]  m_wstrb [4];
  logic [3:0]  m_ready;
  logic [31:0] m_rdata [4];

  assign m_valid = {m3_valid, m2_valid, m1_valid, m0_valid};

  assign m_addr[0] = m0_addr;
  assign m_addr[1] = m1_addr;
  assign m_addr[2] = m2_addr;
  assign m_addr[3] = m3_addr;

  assign m_wdata[0] = m0_wdata;
  assign m_wdata[1] = m1_wdata;
  assign m_wdata[2] = m2_wdata;
  assign m_wdata[3] = m3_wdata;

  assign m_wstrb[0] = m0_wstrb;
  assign m_wstrb[1] = m1_wstrb;
  assign m_wstrb[2] = m2_wstrb;
  assign m_wstrb[3] = m3_wstrb;

  logic        is_busy;
  logic        own_valid;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wstrb;
  logic        tmo;

  assign is_busy   = (state_q == BUSY);
  assign own_valid = m_valid[owner_q];
  assign own_addr  = m_addr[owner_q];
  assign own_wdata = m_wdata[owner_q];
  assign own_wstrb = m_wstrb[owner_q];

  // A same-cycle s_ready beats the timeout.
  assign tmo = TMO_EN && is_busy &&
               (cnt_q == TMO_LAST) && !s_ready;

  // Requests rotated so bit 0 is the master after last.
  logic [3:0] req_rot;
  logic [1:0] grant_off;
  logic [1:0] grant;

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < 4; i++) begin
      req_rot[i] = m_valid[last_q + 2'(i + 1)];
    end
  end

  always_comb begin
    grant_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) grant_off = 2'(i);
    end
  end

  assign grant = last_q + 2'd1 + grant_off;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d = BUSY;
          owner_d = grant;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (tmo || !own_valid || s_ready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_flag_d   = err_flag_q;
    err_master_d = err_master_q;
    err_addr_d   = err_addr_q;
    if (tmo && (!err_flag_q || err_clr)) begin
      err_flag_d   = 1'b1;
      err_master_d = owner_q;
      err_addr_d   = own_addr;
    end else if (err_clr) begin
      err_flag_d   = 1'b0;
      err_master_d = 2'd0;
      err_addr_d   = 32'd0;
    end
  end

  always_comb begin
    m_ready = '0;
    for (int i = 0; i < 4; i++) begin
      m_rdata[i] = 32'd0;
    end
    s_valid = 1'b0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    s_wstrb = 4'd0;
    if (is_busy) begin
      s_valid = own_valid && !tmo;
      s_addr  = own_addr;
      s_wdata = own_wdata;
      s_wstrb = own_wstrb;
      m_ready[owner_q] = tmo || (s_ready && own_valid);
      m_rdata[owner_q] = tmo ? ERR_RDATA : s_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_q       <= 2'd3;
      cnt_q        <= 8'd0;
      err_flag_q   <= 1'b0;
      err_master_q <= 2'd0;
      err_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      err_master_q <= err_master_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign m0_ready = m_ready[0];
  assign m1_ready = m_ready[1];
  assign m2_ready = m_ready[2];
  assign m3_ready = m_ready[3];

  assign m0_rdata = m_rdata[0];
  assign m1_rdata = m_rdata[1];
  assign m2_rdata = m_rdata[2];
  assign m3_rdata = m_rdata[3];

  assign busy       = is_busy;
  assign owner      = owner_q;
  assign err_flag   = err_flag_q;
  assign err_master = err_master_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_bus4to1_rr.sv
// Bench for bus4to1_rr: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_bus4to1_rr;

  localparam int TMO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  mv;
  logic [31:0] ma [4];
  logic [31:0] mw [4];
  logic [3:0]  ms [4];
  logic        sr;
  logic [31:0] srd;
  logic        eclr;

  logic        m0_ready, m1_ready, m2_ready, m3_ready;
  logic [31:0] m0_rdata, m1_rdata, m2_rdata, m3_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        busy;
  logic [1:0]  owner;
  logic        err_flag;
  logic [1:0]  err_master;
  logic [31:0] err_addr;

  logic [3:0]  rdy;
  logic [31:0] rd [4];
  assign rdy = {m3_ready, m2_ready, m1_ready, m0_ready};
  assign rd[0] = m0_rdata;
  assign rd[1] = m1_rdata;
  assign rd[2] = m2_rdata;
  assign rd[3] = m3_rdata;

  bus4to1_rr #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_addr(ma[0]),
    .m0_rdata(m0_rdata), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
    .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_addr(ma[1]),
    .m1_rdata(m1_rdata), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
    .m2_valid(mv[2]), .m2_ready(m2_ready), .m2_addr(ma[2]),
    .m2_rdata(m2_rdata), .m2_wdata(mw[2]), .m2_wstrb(ms[2]),
    .m3_valid(mv[3]), .m3_ready(m3_ready), .m3_addr(ma[3]),
    .m3_rdata(m3_rdata), .m3_wdata(mw[3]), .m3_wstrb(ms[3]),
    .s_valid(s_valid), .s_ready(sr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(srd), .s_wstrb(s_wstrb),
    .busy(busy), .owner(owner),
    .err_flag(err_flag), .err_master(err_master),
    .err_addr(err_addr), .err_clr(eclr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a master holds the bus until done/abandoned/timed out.
  bit          m_busy;
  int          m_own, m_last, m_cnt;
  bit          m_ef;
  int          m_em;
  logic [31:0] m_ea;
  logic [3:0]  prev_rdy;

  task automatic mreset();
    m_busy = 0; m_own = 0; m_last = 3; m_cnt = 0;
    m_ef = 0; m_em = 0; m_ea = 32'd0; prev_rdy = 4'd0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic fin();
    bit          tmo;
    bit          found;
    logic [3:0]  er;
    logic [31:0] erd;
    int          o;
    o   = m_own;
    tmo = m_busy && (m_cnt == TMO - 1) && !sr;
    er  = 4'd0;
    if (m_busy && (tmo || (sr && mv[o]))) er[o] = 1'b1;
    chk("busy", busy, m_busy);
    chk("owner", owner, o);
    chk("s_valid", s_valid, m_busy && mv[o] && !tmo);
    chk("s_addr", s_addr, m_busy ? ma[o] : 32'd0);
    chk("s_wdata", s_wdata, m_busy ? mw[o] : 32'd0);
    chk("s_wstrb", s_wstrb, m_busy ? ms[o] : 4'd0);
    chk("m_ready", rdy, er);
    for (int i = 0; i < 4; i++) begin
      erd = (m_busy && i == o) ? (tmo ? ERR : srd) : 32'd0;
      chk($sformatf("m%0d_rdata", i), rd[i], erd);
    end
    chk("err_flag", err_flag, m_ef);
    chk("err_master", err_master, m_em);
    chk("err_addr", err_addr, m_ea);
    prev_rdy = er;
    if (tmo && (!m_ef || eclr)) begin
      m_ef = 1; m_em = o; m_ea = ma[o];
    end else if (eclr) begin
      m_ef = 0; m_em = 0; m_ea = 32'd0;
    end
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && mv[(m_last + k) % 4]) begin
          found = 1; m_own = (m_last + k) % 4;
          m_busy = 1; m_cnt = 0;
        end
      end
    end else if (tmo || !mv[o] || sr) begin
      m_busy = 0; m_last = o;
    end else begin
      m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2; resetn = 1'b0; #1;
    chk("ar_svalid", s_valid, 1'b0);
    chk("ar_ready", rdy, 4'd0);
    chk("ar_busy", busy, 1'b0);
    mreset();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic idle_in();
    mv = 4'd0; sr = 1'b0; srd = 32'd0; eclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ma[i] = 32'd0; mw[i] = 32'd0; ms[i] = 4'd0;
    end
  endtask

  task automatic rand_stim();
    bit done;
    for (int i = 0; i < 4; i++) begin
      done = mv[i] && prev_rdy[i];
      if (mv[i] && !done) begin
        if ($urandom_range(0, 39) == 0) mv[i] = 1'b0;
      end else begin
        mv[i] = ($urandom_range(0, 2) == 0);
        if (mv[i]) begin
          ma[i] = $urandom; mw[i] = $urandom;
          ms[i] = 4'($urandom);
        end
      end
    end
    eclr = ($urandom_range(0, 19) == 0);
    srd  = $urandom;
    sr   = m_busy && mv[m_own] && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int n;
    int ord [5];
    int ccy [5];
    int exp_ord [5];
    int j;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      ord[k] = 0; ccy[k] = 0;
    end
    idle_in();
    mreset();
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_svalid", s_valid, 1'b0);
    chk("rst_ready", rdy, 4'd0);
    chk("rst_err", err_flag, 1'b0);
    resetn = 1'b1;

    // single master read
    mv[2] = 1'b1; ma[2] = 32'h100;
    settle(); chk("sm_idle", busy, 1'b0); fin();
    settle(); chk("sm_svalid", s_valid, 1'b1);
    chk("sm_saddr", s_addr, 32'h100); fin();
    sr = 1'b1; srd = 32'h12345678;
    settle(); chk("sm_ready", m2_ready, 1'b1);
    chk("sm_rdata", m2_rdata, 32'h12345678); fin();
    mv[2] = 1'b0; sr = 1'b0;
    settle(); chk("sm_done", busy, 1'b0);
    chk("sm_owner", owner, 2'd2); fin();

    // fairness under a 4-way tie with an always-ready slave
    do_reset();
    mv = 4'hF; sr = 1'b1;
    for (int i = 0; i < 4; i++) ma[i] = 32'h1000 * (i + 1);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (rdy != 4'd0 && n < 5) begin
        j = 0;
        for (int b = 0; b < 4; b++) if (rdy[b]) j = b;
        ord[n] = j; ccy[n] = c; n++;
      end
      fin();
    end
    chk("fair_count", n, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("fair_ord%0d", k), ord[k], exp_ord[k]);
    for (int k = 1; k < 5; k++)
      chk($sformatf("fair_gap%0d", k), ccy[k] - ccy[k-1], 2);
    mv = 4'd0; sr = 1'b0;

    // abandon
    mv[1] = 1'b1; ma[1] = 32'h2000;
    settle(); fin();
    settle(); chk("ab_owner", owner, 2'd1); fin();
    mv[1] = 1'b0;
    settle(); chk("ab_noready", m1_ready, 1'b0); fin();
    mv[1] = 1'b1; mv[2] = 1'b1; ma[2] = 32'h2100;
    settle(); chk("ab_idle", busy, 1'b0); fin();
    sr = 1'b1;
    settle(); chk("ab_next", owner, 2'd2);
    chk("ab_m2_ready", m2_ready, 1'b1); fin();
    mv = 4'd0; sr = 1'b0;
    settle(); fin();

    // timeout capture, second timeout, clear
    mv[3] = 1'b1; ma[3] = 32'hF00; mw[3] = 32'h55AA; ms[3] = 4'hF;
    settle(); fin();
    for (int b = 1; b <= 3; b++) begin
      settle(); chk($sformatf("to_wait%0d", b), m3_ready, 1'b0); fin();
    end
    settle(); chk("to_ready", m3_ready, 1'b1);
    chk("to_rdata", m3_rdata, ERR);
    chk("to_svalid", s_valid, 1'b0); fin();
    mv[3] = 1'b0; mv[1] = 1'b1; ma[1] = 32'h200; ms[1] = 4'd0;
    settle(); chk("to_flag", err_flag, 1'b1);
    chk("to_master", err_master, 2'd3);
    chk("to_addr", err_addr, 32'hF00); fin();
    repeat (4) begin settle(); fin(); end
    mv[1] = 1'b0;
    settle(); chk("to2_flag", err_flag, 1'b1);
    chk("to2_master", err_master, 2'd3);
    chk("to2_addr", err_addr, 32'hF00); fin();
    eclr = 1'b1;
    settle(); fin();
    eclr = 1'b0;
    settle(); chk("clr_flag", err_flag, 1'b0);
    chk("clr_addr", err_addr, 32'd0); fin();

    // s_ready on the timeout cycle
    mv[0] = 1'b1; ma[0] = 32'h300;
    settle(); fin();
    repeat (3) begin settle(); fin(); end
    sr = 1'b1; srd = 32'hCAFEF00D;
    settle(); chk("race_ready", m0_ready, 1'b1);
    chk("race_rdata", m0_rdata, 32'hCAFEF00D);
    chk("race_svalid", s_valid, 1'b1); fin();
    mv[0] = 1'b0; sr = 1'b0;
    settle(); chk("race_flag", err_flag, 1'b0);
    chk("race_busy", busy, 1'b0); fin();

    // async reset between edges while BUSY
    mv[1] = 1'b1; ma[1] = 32'h400;
    settle(); fin();
    sr = 1'b1; srd = 32'h77;
    #1; chk("pre_rst_ready", m1_ready, 1'b1);
    do_reset();
    sr = 1'b0; mv = 4'hF;
    settle(); fin();
    settle(); chk("ar_winner", owner, 2'd0); fin();
    idle_in();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rand_stim();
      settle();
      fin();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
